// File: rtl/ps2_device_if.sv
// Internal-side handshake bundle of the PS/2 device engine: the TX byte
// stream toward the host and the RX command stream from the host.
interface ps2_device_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       busy;

  // Master: the scan-code source / command sink using the engine.
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_error, busy
  );

  // Slave: the PS/2 device engine itself.
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_error, busy
  );
endinterface

// File: rtl/ps2_device.sv
// PS/2 device-side protocol engine. Generates the PS/2 clock, sends bytes
// to the host (odd parity, LSB first) and receives host commands with the
// device acknowledge. Pins are open-drain: *_oe = 1 pulls the line low.
module ps2_device #(
  parameter int CLK_HZ = 50000000,
  parameter int PS2_HZ = 12500
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe,
  ps2_device_if.slave bus
);
  localparam int HALF     = CLK_HZ / (2 * PS2_HZ);
  localparam int IDLE_CYC = CLK_HZ / 20000;
  localparam int CW       = 20;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC);
  // After the device releases the clock it takes the synchronizer a couple
  // of cycles to see it high again; ignore "clock low" until then so our
  // own low phase is not mistaken for a host inhibit.
  localparam logic [CW-1:0] SETTLE    = CW'(3);

  typedef enum logic [3:0] {
    IDLE, TX_CHECK, TX_HI, TX_LO, TX_END,
    RX_REQ, RX_LO, RX_HI, RX_ACK_HI, RX_ACK_LO, INHIBIT
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] req_reg, req_next, req_count;
  logic [3:0]    bit_reg, bit_next;
  logic [8:0]    shift_reg, shift_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          rx_valid_reg, rx_valid_next;
  logic          rx_error_reg, rx_error_next;
  logic          busy_reg, busy_next;
  logic          clk_oe_reg, clk_oe_next;
  logic          dat_oe_reg, dat_oe_next;
  logic [7:0]    hold_data_reg;
  logic          hold_full_reg;
  logic          tx_done;
  logic          host_req;

  // Pin synchronizers: index 0 = clock, 1 = data. Reset to the idle-high level.
  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  assign pin_raw = {ps2_dat_in, ps2_clk_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic [1:0] sync_reg;
    // Two-stage synchronizer for one raw pin level.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) sync_reg <= 2'b11;
      else                sync_reg <= {sync_reg[0], pin_raw[gi]};
    end
    assign pin_sync[gi] = sync_reg[1];
  end

  logic sclk, sdat;
  assign sclk = pin_sync[0];
  assign sdat = pin_sync[1];

  // Level of frame bit idx for byte d: start, data[0..7], odd parity, stop.
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d);
    logic b;
    b = 1'b1;
    if (idx == 4'd0)      b = 1'b0;
    else if (idx <= 4'd8) b = d[3'(idx - 4'd1)];
    else if (idx == 4'd9) b = ~^d;
    return b;
  endfunction

  // State, timers and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      req_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_error_reg <= 1'b0;
      busy_reg     <= 1'b0;
      clk_oe_reg   <= 1'b0;
      dat_oe_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      req_reg      <= req_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      rx_error_reg <= rx_error_next;
      busy_reg     <= busy_next;
      clk_oe_reg   <= clk_oe_next;
      dat_oe_reg   <= dat_oe_next;
    end
  end

  // One-entry TX holding register; released only by a completed frame.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
    end else if (tx_done) begin
      hold_full_reg <= 1'b0;
    end else if (!hold_full_reg && bus.tx_valid) begin
      hold_full_reg <= 1'b1;
      hold_data_reg <= bus.tx_data;
    end
  end

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + CW'(1);
    req_next      = '0;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rx_error_next = 1'b0;
    tx_done       = 1'b0;
    req_count     = (sclk && !sdat) ? req_reg + CW'(1) : '0;
    host_req      = sclk && !sdat && (req_reg == HALF_LAST);

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        req_next = req_count;
        if (host_req) begin
          state_next = RX_REQ;
          bit_next   = '0;
        end else if (hold_full_reg) begin
          state_next = TX_CHECK;
        end
      end
      TX_CHECK: begin
        req_next = req_count;
        if (host_req) begin
          state_next = RX_REQ;
          cnt_next   = '0;
          bit_next   = '0;
        end else if (!(sclk && sdat)) begin
          cnt_next = '0;
        end else if (cnt_reg == IDLE_LAST) begin
          state_next = TX_HI;
          cnt_next   = '0;
          bit_next   = '0;
        end
      end
      TX_HI: begin
        if (!sclk && !clk_oe_reg && cnt_reg >= SETTLE) begin
          state_next = INHIBIT;
          cnt_next   = '0;
        end else if (cnt_reg == HALF_LAST) begin
          state_next = TX_LO;
          cnt_next   = '0;
        end
      end
      TX_LO: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (bit_reg == 4'd10) begin
            state_next = TX_END;
          end else begin
            state_next = TX_HI;
            bit_next   = bit_reg + 4'd1;
          end
        end
      end
      TX_END: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          tx_done    = 1'b1;
        end
      end
      INHIBIT: begin
        cnt_next = '0;
        if (sclk) begin
          state_next = sdat ? IDLE : RX_REQ;
          bit_next   = '0;
        end
      end
      RX_REQ: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = RX_LO;
          cnt_next   = '0;
        end
      end
      RX_LO: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = RX_HI;
          cnt_next   = '0;
        end
      end
      RX_HI: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (bit_reg == 4'd9) begin
            // Stop bit: acknowledge only a properly terminated frame.
            if (sdat) begin
              state_next = RX_ACK_HI;
            end else begin
              state_next    = IDLE;
              rx_error_next = 1'b1;
            end
          end else begin
            shift_next = {sdat, shift_reg[8:1]};
            bit_next   = bit_reg + 4'd1;
            state_next = RX_LO;
          end
        end
      end
      RX_ACK_HI: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = RX_ACK_LO;
          cnt_next   = '0;
        end
      end
      RX_ACK_LO: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (^shift_reg) begin
            rx_data_next  = shift_reg[7:0];
            rx_valid_next = 1'b1;
          end else begin
            rx_error_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    busy_next   = !(state_next == IDLE || state_next == TX_CHECK);
    clk_oe_next = state_next inside {TX_LO, RX_LO, RX_ACK_LO};
    dat_oe_next = (state_next inside {RX_ACK_HI, RX_ACK_LO}) ||
                  ((state_next inside {TX_HI, TX_LO}) && !frame_bit(bit_next, hold_data_reg));
  end

  assign ps2_clk_oe   = clk_oe_reg;
  assign ps2_dat_oe   = dat_oe_reg;
  assign bus.tx_ready = ~hold_full_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.rx_error = rx_error_reg;
  assign bus.busy     = busy_reg;
endmodule

// File: tb/tb_ps2_device.sv
// Directed bench for ps2_device acting as the PS/2 host: pull-up pin model,
// host request/inhibit generation and frame capture at the clock falls.
module tb_ps2_device;
  localparam int CLK_HZ   = 1000000;
  localparam int PS2_HZ   = 12500;
  localparam int HALF     = 40;
  localparam int IDLE_CYC = 50;

  // Expected frames, bit i = line level at fall i: {stop, parity, data, start}.
  localparam logic [10:0] FRAME_1C = 11'b1_0_0001_1100_0;
  localparam logic [10:0] FRAME_AA = 11'b1_1_1010_1010_0;
  localparam logic [10:0] FRAME_55 = 11'b1_1_0101_0101_0;

  logic clk = 1'b0;
  logic rst_n;
  logic host_clk_low, host_dat_low;
  logic clk_oe, dat_oe;
  wire  ps2_clk_pin = !(clk_oe || host_clk_low);
  wire  ps2_dat_pin = !(dat_oe || host_dat_low);

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_error = 0;

  ps2_device_if bus_if();

  ps2_device #(.CLK_HZ(CLK_HZ), .PS2_HZ(PS2_HZ)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .ps2_clk_in(ps2_clk_pin), .ps2_dat_in(ps2_dat_pin),
    .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe), .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus_if.rx_valid === 1'b1) n_valid++;
    if (bus_if.rx_error === 1'b1) n_error++;
  end

  // Wait for a falling edge on the clock pin, bounded by limit cycles.
  task automatic wait_fall(input int limit, output bit ok, output int n);
    logic prev;
    ok = 1'b0;
    n = 0;
    prev = ps2_clk_pin;
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      if (prev && !ps2_clk_pin) ok = 1'b1;
      prev = ps2_clk_pin;
    end
  endtask

  // Capture one device->host frame at the 11 clock falls.
  task automatic host_recv(input int first_limit, output bit ok, output logic [10:0] bits,
                           output int first_wait, output int min_gap, output int max_gap,
                           output bit ready_seen);
    bit f;
    int n;
    ok = 1'b1; bits = '0; first_wait = 0; min_gap = 1 << 30; max_gap = 0; ready_seen = 1'b0;
    for (int i = 0; i < 11; i++) begin
      wait_fall((i == 0) ? first_limit : 4 * HALF, f, n);
      if (!f) begin
        ok = 1'b0;
        break;
      end
      bits[i] = ps2_dat_pin;
      if (bus_if.tx_ready === 1'b1) ready_seen = 1'b1;
      if (i == 0) first_wait = n;
      else begin
        if (n < min_gap) min_gap = n;
        if (n > max_gap) max_gap = n;
      end
    end
  endtask

  // Host request-to-send followed by a host->device frame; optionally
  // presents a TX byte tx_at cycles after the clock is released.
  task automatic host_send(input logic [7:0] d, input logic par, input int tx_at,
                           input logic [7:0] txd, output bit ok, output logic ack);
    logic [9:0] fr;
    bit f;
    int n;
    fr = {1'b1, par, d};
    ok = 1'b1;
    ack = 1'b0;
    @(negedge clk);
    host_clk_low = 1'b1;
    repeat (100) @(negedge clk);
    host_dat_low = 1'b1;
    repeat (5) @(negedge clk);
    host_clk_low = 1'b0;
    if (tx_at >= 0) begin
      repeat (tx_at) @(negedge clk);
      bus_if.tx_data = txd;
      bus_if.tx_valid = 1'b1;
      @(negedge clk);
      bus_if.tx_valid = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      wait_fall(300, f, n);
      if (!f) begin
        ok = 1'b0;
        break;
      end
      host_dat_low = !fr[k];
    end
    if (ok) begin
      wait_fall(300, f, n);
      if (!f) ok = 1'b0;
      else ack = !ps2_dat_pin;
    end
    host_dat_low = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b want=0", clk_oe); end
    total++; if (dat_oe !== 1'b0) begin bad++; $display("FAIL reset_dat_oe got=%b want=0", dat_oe); end
    total++; if (bus_if.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", bus_if.tx_ready); end
    total++; if (bus_if.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", bus_if.rx_data); end
    total++; if (bus_if.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", bus_if.rx_valid); end
    total++; if (bus_if.rx_error !== 1'b0) begin bad++; $display("FAIL reset_rx_error got=%b want=0", bus_if.rx_error); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_if.busy); end
    $display("reset: outputs checked");
  endtask

  task automatic test_tx_1c();
    bit ok, rs;
    logic [10:0] bits;
    int fw, mn, mx, n;
    @(negedge clk);
    bus_if.tx_data = 8'h1C;
    bus_if.tx_valid = 1'b1;
    @(negedge clk);
    bus_if.tx_valid = 1'b0;
    host_recv(400, ok, bits, fw, mn, mx, rs);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL tx1c_frame_timeout got=%b want=1", ok); end
    total++; if (bits !== FRAME_1C) begin bad++; $display("FAIL tx1c_bits got=%b want=%b", bits, FRAME_1C); end
    total++; if (fw < IDLE_CYC + 2 + HALF || fw > 200) begin bad++; $display("FAIL tx1c_start_latency got=%0d want>=%0d", fw, IDLE_CYC + 2 + HALF); end
    total++; if (mn != 2 * HALF || mx != 2 * HALF) begin bad++; $display("FAIL tx1c_fall_spacing got=%0d..%0d want=%0d", mn, mx, 2 * HALF); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL tx1c_ready_in_frame got=%b want=0", rs); end
    n = 0;
    while (bus_if.tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++; if (n != 2 * HALF) begin bad++; $display("FAIL tx1c_ready_return got=%0d want=%0d", n, 2 * HALF); end
    total++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin bad++; $display("FAIL tx1c_release got=%b%b want=00", clk_oe, dat_oe); end
    $display("tx 0x1C: bits=%b first=%0d gap=%0d ready_after=%0d", bits, fw, mn, n);
  endtask

  task automatic test_rx(input logic [7:0] d, input logic par, input logic exp_valid,
                         input logic [7:0] exp_data);
    bit ok;
    logic ack;
    int v0, e0;
    v0 = n_valid;
    e0 = n_error;
    host_send(d, par, -1, 8'h00, ok, ack);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rx%02h_timeout got=%b want=1", d, ok); end
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL rx%02h_ack got=%b want=1", d, ack); end
    repeat (2 * HALF) @(negedge clk);
    total++; if (n_valid - v0 != int'(exp_valid)) begin bad++; $display("FAIL rx%02h_valid_pulses got=%0d want=%0d", d, n_valid - v0, exp_valid); end
    total++; if (n_error - e0 != int'(!exp_valid)) begin bad++; $display("FAIL rx%02h_error_pulses got=%0d want=%0d", d, n_error - e0, !exp_valid); end
    total++; if (bus_if.rx_data !== exp_data) begin bad++; $display("FAIL rx%02h_data got=%h want=%h", d, bus_if.rx_data, exp_data); end
    $display("rx 0x%02h par=%b: ack=%b valid=%0d error=%0d data=%02h", d, par, ack, n_valid - v0, n_error - e0, bus_if.rx_data);
  endtask

  task automatic test_inhibit();
    bit ok, f, rs;
    logic [10:0] bits;
    int fw, mn, mx, n;
    @(negedge clk);
    bus_if.tx_data = 8'hAA;
    bus_if.tx_valid = 1'b1;
    @(negedge clk);
    bus_if.tx_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_fall((i == 0) ? 400 : 4 * HALF, f, n);
      if (!f) ok = 1'b0;
    end
    n = 0;
    while (ps2_clk_pin !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL inh_pre_timeout got=%b want=1", ok); end
    // Data bit 6 of 0xAA is a zero, so the device is driving data low here.
    total++; if (dat_oe !== 1'b1) begin bad++; $display("FAIL inh_pre_dat_oe got=%b want=1", dat_oe); end
    host_clk_low = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin bad++; $display("FAIL inh_release got=%b%b want=00", clk_oe, dat_oe); end
    total++; if (bus_if.tx_ready !== 1'b0) begin bad++; $display("FAIL inh_tx_ready got=%b want=0", bus_if.tx_ready); end
    total++; if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL inh_busy got=%b want=1", bus_if.busy); end
    repeat (97) @(negedge clk);
    host_clk_low = 1'b0;
    host_recv(400, ok, bits, fw, mn, mx, rs);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL inh_resend_timeout got=%b want=1", ok); end
    total++; if (bits !== FRAME_AA) begin bad++; $display("FAIL inh_resend_bits got=%b want=%b", bits, FRAME_AA); end
    total++; if (fw < IDLE_CYC + HALF) begin bad++; $display("FAIL inh_resend_latency got=%0d want>=%0d", fw, IDLE_CYC + HALF); end
    repeat (2 * HALF + 2) @(negedge clk);
    total++; if (bus_if.tx_ready !== 1'b1) begin bad++; $display("FAIL inh_ready_after got=%b want=1", bus_if.tx_ready); end
    $display("inhibit 0xAA: resent bits=%b first=%0d", bits, fw);
  endtask

  task automatic test_contention();
    bit ok, rs;
    logic ack;
    logic [10:0] bits;
    int fw, mn, mx, v0;
    v0 = n_valid;
    // Request becomes stable 42 cycles after the clock release
    // (2 synchronizer stages + HALF); present the byte in that cycle.
    host_send(8'hFF, 1'b1, 41, 8'h55, ok, ack);
    total++; if (ok !== 1'b1 || ack !== 1'b1) begin bad++; $display("FAIL cont_rx_ack got=%b%b want=11", ok, ack); end
    total++; if (bus_if.tx_ready !== 1'b0) begin bad++; $display("FAIL cont_byte_held got=%b want=0", bus_if.tx_ready); end
    repeat (60) @(negedge clk);
    total++; if (n_valid - v0 != 1 || bus_if.rx_data !== 8'hFF) begin bad++; $display("FAIL cont_rx_first got=%0d/%h want=1/ff", n_valid - v0, bus_if.rx_data); end
    total++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin bad++; $display("FAIL cont_tx_waits got=%b%b want=00", clk_oe, dat_oe); end
    host_recv(400, ok, bits, fw, mn, mx, rs);
    total++; if (ok !== 1'b1 || bits !== FRAME_55) begin bad++; $display("FAIL cont_tx_bits got=%b want=%b", bits, FRAME_55); end
    repeat (2 * HALF + 2) @(negedge clk);
    total++; if (bus_if.tx_ready !== 1'b1) begin bad++; $display("FAIL cont_ready_after got=%b want=1", bus_if.tx_ready); end
    $display("contention: rx=%02h then tx bits=%b", bus_if.rx_data, bits);
  endtask

  task automatic test_reset_mid_rx();
    bit f;
    int n, v0, e0;
    logic [7:0] d;
    d = 8'hA5;
    v0 = n_valid;
    e0 = n_error;
    @(negedge clk);
    host_clk_low = 1'b1;
    repeat (100) @(negedge clk);
    host_dat_low = 1'b1;
    repeat (5) @(negedge clk);
    host_clk_low = 1'b0;
    f = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (f) begin
        wait_fall(300, f, n);
        host_dat_low = !d[k];
      end
    end
    // Now in the low phase of the pulse for bit 4.
    total++; if (f !== 1'b1 || clk_oe !== 1'b1) begin bad++; $display("FAIL rstrx_pre got=%b%b want=11", f, clk_oe); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin bad++; $display("FAIL rstrx_async got=%b%b want=00", clk_oe, dat_oe); end
    host_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    total++; if (n_valid != v0 || n_error != e0) begin bad++; $display("FAIL rstrx_no_pulse got=%0d/%0d want=0/0", n_valid - v0, n_error - e0); end
    total++; if (bus_if.tx_ready !== 1'b1) begin bad++; $display("FAIL rstrx_tx_ready got=%b want=1", bus_if.tx_ready); end
    total++; if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL rstrx_busy got=%b want=0", bus_if.busy); end
    $display("reset mid-rx: oe=%b%b ready=%b", clk_oe, dat_oe, bus_if.tx_ready);
  endtask

  initial begin
    rst_n = 1'b0;
    host_clk_low = 1'b0;
    host_dat_low = 1'b0;
    bus_if.tx_data = 8'h00;
    bus_if.tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_tx_1c();
    repeat (20) @(negedge clk);
    test_rx(8'hED, 1'b1, 1'b1, 8'hED);
    repeat (20) @(negedge clk);
    test_rx(8'hF4, 1'b1, 1'b0, 8'hED);
    repeat (20) @(negedge clk);
    test_inhibit();
    repeat (20) @(negedge clk);
    test_contention();
    repeat (20) @(negedge clk);
    test_reset_mid_rx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
